note_field_scroller: RTL and testbench
======================================

NOTE_FIELD_SCROLLER -- requirements
Module: note_field_scroller

Interface
REQ-001 SHALL have parameter SCROLL_DIV, default 50000, meaning clock cycles per scroll step (minimum 2).
REQ-002 SHALL have port clk  in  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start  in  1  level; begin or restart game.
REQ-005 SHALL have port stop  in  1  level; return to IDLE.
REQ-006 SHALL have port pause  in  1  level; freeze play while high.
REQ-007 SHALL have port note_in  in  8  next top-row pattern; bit i = lane i.
REQ-008 SHALL have port note_valid  in  1  note_in holds a pattern to consume.
REQ-009 SHALL have port note_ack  out  1  one-cycle pulse; note_in consumed this step.
REQ-010 SHALL have port btn  in  8  lane buttons, synchronous, debounced, active-high.
REQ-011 SHALL have port MainGraphic  out  64  field; [63:56] top row ... [7:0] bottom (hit) row.
REQ-012 SHALL have port hit  out  1  one-cycle pulse; at least one lane hit.
REQ-013 SHALL have port miss  out  1  one-cycle pulse; at least one note left the field unhit.
REQ-014 SHALL have port score  out  16  total hits, saturating at 16'hFFFF.
REQ-015 SHALL have port combo  out  8  consecutive hits since last miss, saturating at 8'hFF.
REQ-016 SHALL have port state  out  2  00 IDLE, 01 PLAY, 10 PAUSE.

Function
REQ-017 SHALL use FSM transitions with precedence stop > start > pause: any state with stop=1 -> IDLE; start=1 -> PLAY with clear; PLAY with pause=1 -> PAUSE; PAUSE with pause=0 -> PLAY.
REQ-018 SHALL, on clear, zero field, score, combo, prescaler; clear takes effect on the same edge that enters PLAY.
REQ-019 SHALL, in IDLE, hold field, score and combo; no steps, no hits, no misses, note_ack=0.
REQ-020 SHALL, in PAUSE, hold prescaler, field, score and combo; button presses ignored.
REQ-021 SHALL, in PLAY, count the prescaler 0..SCROLL_DIV-1 and wrap; a step occurs on the edge where the count equals SCROLL_DIV-1.
REQ-022 SHALL define press[i] = btn[i] & ~btn_prev[i]; btn_prev updates every cycle in all states.
REQ-023 SHALL, in PLAY, for each lane with press[i]=1 and bottom[i]=1: clear bottom[i]; hit=1 next cycle; score += popcount(hit lanes) saturating; press on an empty lane has no effect.
REQ-024 SHALL, on a step, evaluate misses on the bottom row after same-cycle hits are removed: any remaining bit -> miss=1, combo=0.
REQ-025 SHALL, on a step, shift rows down one (bottom discarded); top row := note_in and note_ack=1 if note_valid=1, else top row := 0 and note_ack=0.
REQ-026 SHALL apply the combo rule: if miss this cycle then combo=0, else combo += popcount(hit lanes) saturating.
REQ-027 SHALL assert hit and miss together when a same-cycle hit and miss occur; score still counts the hits.
REQ-028 SHALL register all outputs; hit, miss and note_ack are never high for more than one consecutive cycle per event.

Reset
REQ-029 SHALL, on rst_n=0, immediately set state=IDLE, field=0, score=0, combo=0, prescaler=0, hit=miss=note_ack=0, btn_prev=8'hFF (no spurious press on release).
REQ-030 SHALL discard all game progress on reset mid-play; after release the block remains in IDLE until start.

Verification (SCROLL_DIV=4)
REQ-031 SHALL cover: rst_n low during PLAY with non-zero field/score -> all outputs zero, state=00 asynchronously.
REQ-032 SHALL cover: start pulse, note_valid=1, note_in=8'h81 for one step then note_valid=0 -> note_ack pulses once, MainGraphic[63:56]=8'h81 after step 1, reaching [7:0] after step 8, other rows 0.
REQ-033 SHALL cover: with bottom=8'h81, btn[0] rises -> next cycle bottom=8'h80, hit=1, score=1, combo=1; holding btn[0] gives no second hit.
REQ-034 SHALL cover: following step with lane 7 unpressed -> miss=1, combo=0, score=1, bottom row replaced by row 1.
REQ-035 SHALL cover: btn[7] rise on the exact step edge with bottom=8'h81 -> hit=1 and miss=1 same cycle, score+1, combo=0.
REQ-036 SHALL cover: pause=1 for 20 cycles -> MainGraphic, prescaler, score frozen, presses ignored; pause=0 resumes stepping where it left off; stop -> state=00, field held.

Source files
------------

// File: rtl/note_field_scroller.sv
// note_field_scroller: 8-lane falling-note field with lane hit/miss detection, score and combo.
module note_field_scroller #(
    parameter int SCROLL_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        pause,
    input  logic [7:0]  note_in,
    input  logic        note_valid,
    output logic        note_ack,
    input  logic [7:0]  btn,
    output logic [63:0] MainGraphic,
    output logic        hit,
    output logic        miss,
    output logic [15:0] score,
    output logic [7:0]  combo,
    output logic [1:0]  state
);
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] PLAY  = 2'b01;
    localparam logic [1:0] PAUSE = 2'b10;
    localparam int PW = $clog2(SCROLL_DIV);
    logic [PW-1:0] presc;
    logic [7:0]    btn_prev;
    logic [7:0]    hits;
    logic [7:0]    bottom_left;
    logic [3:0]    n_hits;
    logic          step;
    logic          missed;
    logic [16:0]   score_sum;
    logic [8:0]    combo_sum;
    always_comb begin
        step        = presc == PW'(SCROLL_DIV - 1);
        hits        = btn & ~btn_prev & MainGraphic[7:0];
        bottom_left = MainGraphic[7:0] & ~hits;
        missed      = step && |bottom_left;
        n_hits      = '0;
        for (int i = 0; i < 8; i++) n_hits = n_hits + 4'(hits[i]);
        score_sum   = {1'b0, score} + 17'(n_hits);
        combo_sum   = {1'b0, combo} + 9'(n_hits);
    end
    // btn_prev resets high so a button held through reset is not seen as a press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            presc       <= '0;
            btn_prev    <= 8'hFF;
            MainGraphic <= '0;
            score       <= '0;
            combo       <= '0;
            hit         <= 1'b0;
            miss        <= 1'b0;
            note_ack    <= 1'b0;
        end else begin
            btn_prev <= btn;
            hit      <= 1'b0;
            miss     <= 1'b0;
            note_ack <= 1'b0;
            if (stop) state <= IDLE;
            else if (start) begin
                state       <= PLAY;
                presc       <= '0;
                MainGraphic <= '0;
                score       <= '0;
                combo       <= '0;
            end else if (state == PLAY && pause) state <= PAUSE;
            else if (state == PAUSE && !pause) state <= PLAY;
            else if (state == PLAY) begin
                presc       <= step ? '0 : presc + PW'(1);
                MainGraphic <= step ? {note_valid ? note_in : 8'h00, MainGraphic[63:8]}
                                    : {MainGraphic[63:8], bottom_left};
                note_ack    <= step && note_valid;
                hit         <= |hits;
                miss        <= missed;
                score       <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
                combo       <= missed ? 8'h00 : combo_sum[8] ? 8'hFF : combo_sum[7:0];
            end
        end
    end
endmodule

// File: tb/tb_note_field_scroller.sv
// tb_note_field_scroller: directed checks of scrolling, hits, misses, pause, stop and reset with SCROLL_DIV=4.
module tb_note_field_scroller;
    logic        clk = 1'b0;
    logic        rst_n, start, stop, pause, note_valid;
    logic [7:0]  note_in, btn;
    logic        note_ack, hit, miss;
    logic [63:0] MainGraphic;
    logic [15:0] score;
    logic [7:0]  combo;
    logic [1:0]  state;
    int          n_assert = 0;
    int          n_fail = 0;

    note_field_scroller #(.SCROLL_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .note_in(note_in), .note_valid(note_valid), .note_ack(note_ack), .btn(btn),
        .MainGraphic(MainGraphic), .hit(hit), .miss(miss), .score(score),
        .combo(combo), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        note_valid = 1'b0; note_in = 8'h00; btn = 8'h00;
        tick(2);
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_field", MainGraphic, 64'd0);
        chk("rst_score", 64'(score), 64'd0);
        chk("rst_pulses", 64'({hit, miss, note_ack}), 64'd0);
        rst_n = 1'b1;
        tick(2);
        chk("idle_hold", 64'(state), 64'd0);

        // start, first note enters on the fourth edge after start
        start = 1'b1; note_valid = 1'b1; note_in = 8'h81;
        tick(1);
        start = 1'b0;
        chk("start_state", 64'(state), 64'd1);
        chk("start_field", MainGraphic, 64'd0);
        tick(3);
        chk("pre_step_ack", 64'(note_ack), 64'd0);
        tick(1);
        chk("step1_ack", 64'(note_ack), 64'd1);
        chk("step1_field", MainGraphic, 64'h8100_0000_0000_0000);
        note_valid = 1'b0;
        tick(1);
        chk("ack_one_cycle", 64'(note_ack), 64'd0);
        tick(3 + 4 * 5);
        chk("step7_field", MainGraphic, 64'h0000_0000_0000_8100);
        chk("step7_nomiss", 64'(miss), 64'd0);
        tick(4);
        chk("step8_field", MainGraphic, 64'h0000_0000_0000_0081);

        // lane 0 hit, then held button gives nothing more
        btn = 8'h01;
        tick(1);
        chk("hit_field", MainGraphic, 64'h0000_0000_0000_0080);
        chk("hit_pulse", 64'(hit), 64'd1);
        chk("hit_score", 64'(score), 64'd1);
        chk("hit_combo", 64'(combo), 64'd1);
        tick(1);
        chk("held_nohit", 64'(hit), 64'd0);
        chk("held_score", 64'(score), 64'd1);

        // lane 7 left unhit -> miss; second note enters on the same step
        btn = 8'h00; note_valid = 1'b1; note_in = 8'h81;
        tick(2);
        chk("miss_pulse", 64'(miss), 64'd1);
        chk("miss_combo", 64'(combo), 64'd0);
        chk("miss_score", 64'(score), 64'd1);
        chk("miss_field", MainGraphic, 64'h8100_0000_0000_0000);
        chk("miss_ack", 64'(note_ack), 64'd1);
        note_valid = 1'b0;
        tick(1);
        chk("miss_one_cycle", 64'(miss), 64'd0);
        tick(3 + 4 * 6);
        chk("step16_field", MainGraphic, 64'h0000_0000_0000_0081);

        // lane 7 pressed on the step edge: hit and miss together
        tick(3);
        btn = 8'h80;
        tick(1);
        chk("both_hit", 64'(hit), 64'd1);
        chk("both_miss", 64'(miss), 64'd1);
        chk("both_score", 64'(score), 64'd2);
        chk("both_combo", 64'(combo), 64'd0);
        chk("both_field", MainGraphic, 64'd0);
        btn = 8'h00;

        // bring 8'h3C to the bottom row, then pause one edge after a step
        note_valid = 1'b1; note_in = 8'h3C;
        tick(4);
        note_valid = 1'b0;
        tick(28);
        chk("step25_field", MainGraphic, 64'h0000_0000_0000_003C);
        tick(1);
        pause = 1'b1;
        tick(1);
        chk("pause_state", 64'(state), 64'd2);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) btn = 8'h04;
            tick(1);
        end
        chk("pause_field", MainGraphic, 64'h0000_0000_0000_003C);
        chk("pause_score", 64'(score), 64'd2);
        chk("pause_nohit", 64'(hit), 64'd0);
        pause = 1'b0;
        tick(1);
        chk("resume_state", 64'(state), 64'd1);
        tick(2);
        chk("resume_field", MainGraphic, 64'h0000_0000_0000_003C);
        chk("resume_nomiss", 64'(miss), 64'd0);
        note_valid = 1'b1; note_in = 8'h5A;
        tick(1);
        chk("resume_miss", 64'(miss), 64'd1);
        chk("resume_step_field", MainGraphic, 64'h5A00_0000_0000_0000);
        chk("resume_score", 64'(score), 64'd2);
        note_valid = 1'b0;

        // asynchronous reset mid-play
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", 64'(state), 64'd0);
        chk("arst_field", MainGraphic, 64'd0);
        chk("arst_score", 64'(score), 64'd0);
        chk("arst_pulses", 64'({hit, miss, note_ack}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        note_valid = 1'b1;
        tick(5);
        chk("post_rst_idle", 64'(state), 64'd0);
        chk("post_rst_field", MainGraphic, 64'd0);

        // restart, one note, then stop holds the field
        start = 1'b1; note_in = 8'h5A;
        tick(1);
        start = 1'b0;
        tick(4);
        chk("restart_field", MainGraphic, 64'h5A00_0000_0000_0000);
        note_valid = 1'b0;
        stop = 1'b1;
        tick(1);
        chk("stop_state", 64'(state), 64'd0);
        stop = 1'b0; note_valid = 1'b1;
        tick(6);
        chk("stop_field", MainGraphic, 64'h5A00_0000_0000_0000);
        chk("stop_noack", 64'(note_ack), 64'd0);
        chk("stop_score", 64'(score), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
